// File: rtl/pio_input_pkg.sv
// Shared constants for the pio_input switch/button port: register map,
// DATA field positions and button indices.
package pio_input_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int SW_LSB   = 0;
  localparam int LVL_LSB  = 22;
  localparam int EDGE_LSB = 27;

  localparam int NUM_BTN = 5;

  // Button order on the bus is {C,U,L,R,D}
  localparam int BTN_D = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_U = 3;
  localparam int BTN_C = 4;

  function automatic logic [31:0] pack_data(input logic [NUM_BTN-1:0] edges,
                                            input logic [NUM_BTN-1:0] levels,
                                            input logic [15:0]        sw);
    return {edges, levels, 6'b0, sw};
  endfunction

endpackage

// File: rtl/pio_input_btn_debounce.sv
// Single-bit button conditioner: two-flop synchronizer followed by a
// stable-count debouncer; emits the accepted level and a rising pulse.
module btn_debounce
  import pio_input_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == CNT_MAX);

  // Combinational so the owner can latch the event on the same edge level flips
  assign rise = (sync2 != level) && at_max && sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (at_max) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_input.sv
// Memory-mapped switch/button input port with sticky W1C press events.
// Define PIO_INPUT_IRQ_EN to build the irq_mask register and interrupt output.
module pio_input
  import pio_input_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_in,
  input  logic [4:0]  btn_in,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [15:0]        sw_meta;
  logic [15:0]        sw_sync;
  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_edge;
  logic [NUM_BTN-1:0] edge_clr;
  logic [31:0]        data_word;
  logic [31:0]        ctrl_word;
  logic               data_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_in[i]),
      .level  (btn_lvl[i]),
      .rise   (btn_rise[i])
    );
  end

  assign data_wr  = wr_en && (addr == ADDR_DATA);
  assign edge_clr = data_wr ? wr_data[EDGE_LSB +: NUM_BTN] : '0;

  // Set is OR-ed in after the clear so a press landing on a W1C is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_edge <= '0;
    end else begin
      btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
    end
  end

  assign data_word = pack_data(btn_edge, btn_lvl, sw_sync);

`ifdef PIO_INPUT_IRQ_EN
  logic [NUM_BTN-1:0] irq_mask;
  logic [21:0]        unused_wr_bits;

  assign unused_wr_bits = {wr_data[26:5]};
  assign ctrl_word      = {27'b0, irq_mask};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (addr == ADDR_CTRL)) begin
        irq_mask <= wr_data[NUM_BTN-1:0];
      end
      irq <= |(btn_edge & irq_mask);
    end
  end
`else
  logic [26:0] unused_wr_bits;

  assign unused_wr_bits = wr_data[26:0];
  assign ctrl_word      = '0;
  assign irq            = 1'b0;
`endif

  // Reads sample register state before any same-cycle write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (addr == ADDR_CTRL) ? ctrl_word : data_word;
    end
  end

endmodule

// File: tb/tb_pio_input.sv
// Directed scoreboard bench for pio_input with a short debounce window;
// the interrupt checks follow whichever PIO_INPUT_IRQ_EN build is compiled.
module tb_pio_input;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic        rd_en;
  logic        wr_en;
  logic        addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  pio_input #(.DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .btn_in (btn_in),
    .rd_en  (rd_en),
    .wr_en  (wr_en),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] run did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [31:0] expv;
    if (exp_q.size() == 0) begin
      check_output({tag, "_noexp"}, rd_data, 32'hxxxx_xxxx);
    end else begin
      expv = exp_q.pop_front();
      check_output(tag, rd_data, expv);
    end
  endtask

  task automatic apply_read(input string tag, input logic a, input logic [31:0] expv);
    rd_en = 1'b1;
    addr  = a;
    exp_q.push_back(expv);
    step();
    rd_en = 1'b0;
    pop_compare(tag);
  endtask

  task automatic apply_write(input logic a, input logic [31:0] d);
    wr_en   = 1'b1;
    addr    = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic apply_rw(input string tag, input logic [31:0] d, input logic [31:0] expv);
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    addr    = 1'b0;
    wr_data = d;
    exp_q.push_back(expv);
    step();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    pop_compare(tag);
  endtask

  initial begin
    rst = 1'b1; sw_in = '0; btn_in = '0; rd_en = 1'b0; wr_en = 1'b0;
    addr = 1'b0; wr_data = '0;
    step(); step();
    check_output("rst_rd_data", rd_data, 32'h0);
    check_output("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    apply_read("rst_data", 1'b0, 32'h0);
    apply_read("rst_ctrl", 1'b1, 32'h0);

    // Switch path
    sw_in = 16'hA5C3;
    repeat (3) step();
    apply_read("sw_data", 1'b0, 32'h0000_A5C3);
    sw_in = 16'h0;
    repeat (3) step();

    // Short pulses must not reach the debounced level
    repeat (3) begin
      btn_in[0] = 1'b1; step(); step();
      btn_in[0] = 1'b0; step(); step();
    end
    repeat (4) step();
    apply_read("bounce", 1'b0, 32'h0);

    // Press, W1C, release
    btn_in[2] = 1'b1;
    repeat (10) step();
    apply_read("press2", 1'b0, 32'h2100_0000);
    apply_write(1'b0, 32'h2000_0000);
    apply_read("w1c2", 1'b0, 32'h0100_0000);
    btn_in[2] = 1'b0;
    repeat (10) step();
    apply_read("release2", 1'b0, 32'h0);

    // Exact press-to-level latency of 2 + DEB cycles
    btn_in[3] = 1'b1;
    repeat (5) step();
    apply_read("lat_before", 1'b0, 32'h0);
    apply_read("lat_at", 1'b0, 32'h4200_0000);
    apply_write(1'b0, 32'h4000_0000);
    btn_in[3] = 1'b0;
    repeat (10) step();
    apply_read("lat_clean", 1'b0, 32'h0);

`ifdef PIO_INPUT_IRQ_EN
    apply_write(1'b1, 32'h0000_0004);
    apply_read("ctrl_rd", 1'b1, 32'h0000_0004);
    btn_in[1] = 1'b1;
    repeat (10) step();
    check_output("irq_masked", {31'b0, irq}, 32'h0);
    apply_read("press1", 1'b0, 32'h1080_0000);
    btn_in[2] = 1'b1;
    repeat (5) step();
    check_output("irq_pre", {31'b0, irq}, 32'h0);
    step();
    check_output("irq_edge_cyc", {31'b0, irq}, 32'h0);
    step();
    check_output("irq_set", {31'b0, irq}, 32'h1);
    apply_write(1'b0, 32'h2000_0000);
    check_output("irq_wr_cyc", {31'b0, irq}, 32'h1);
    step();
    check_output("irq_cleared", {31'b0, irq}, 32'h0);
    apply_write(1'b1, 32'h0000_0002);
    step();
    check_output("irq_unmask", {31'b0, irq}, 32'h1);
    apply_write(1'b1, 32'h0000_0000);
    step();
    check_output("irq_remask", {31'b0, irq}, 32'h0);
`else
    apply_write(1'b1, 32'h0000_001F);
    apply_read("ctrl_rd_off", 1'b1, 32'h0);
    btn_in[1] = 1'b1;
    repeat (10) step();
    check_output("irq_off", {31'b0, irq}, 32'h0);
    apply_read("press1", 1'b0, 32'h1080_0000);
`endif
    apply_write(1'b0, 32'hF800_0000);
    btn_in = '0;
    repeat (10) step();
    apply_read("irq_clean", 1'b0, 32'h0);

    // W1C landing on the rising cycle: set wins
    btn_in[0] = 1'b1;
    repeat (5) step();
    apply_write(1'b0, 32'h0800_0000);
    apply_read("collide", 1'b0, 32'h0840_0000);
    apply_write(1'b0, 32'h0800_0000);
    apply_read("clr0", 1'b0, 32'h0040_0000);

    // rd_data holds when no read strobe
    sw_in = 16'h1234;
    repeat (3) step();
    check_output("hold", rd_data, 32'h0040_0000);
    sw_in = 16'h0;

    // Reset mid-debounce with button 0 held and button 4 partially counted
`ifdef PIO_INPUT_IRQ_EN
    apply_write(1'b1, 32'h0000_001F);
`endif
    btn_in[4] = 1'b1;
    repeat (3) step();
    #3;
    rst = 1'b1;
    #1;
    check_output("mid_rst_rd", rd_data, 32'h0);
    check_output("mid_rst_irq", {31'b0, irq}, 32'h0);
    step(); step();
    rst = 1'b0;
    apply_read("post_rst_data", 1'b0, 32'h0);
    apply_read("post_rst_ctrl", 1'b1, 32'h0);
    repeat (3) step();
    apply_read("post_rst_before", 1'b0, 32'h0);
    apply_read("post_rst_at", 1'b0, 32'h8C40_0000);
    step();
    check_output("post_rst_irq", {31'b0, irq}, 32'h0);

    // Simultaneous read and write returns the pre-write value
    apply_rw("rw_both", 32'hF800_0000, 32'h8C40_0000);
    apply_read("rw_after", 1'b0, 32'h0440_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
